// File: rtl/tick_bcd_counter.sv
// Two-digit BCD tick counter with a multiplexed 7-segment scan; optional LEAD_ZERO_BLANK_EN blanks a zero tens digit.
// Latency: cnt_bcd/carry/running update 1 clk after the tick_in rise is sampled; seg/dig_sel are registered from current state.
// Backpressure: none; tick rises in STOP are dropped, never queued.
module tick_bcd_counter #(
  parameter int unsigned CNT_MAX     = 59,
  parameter int unsigned SCAN_DIV    = 50_000,
  parameter bit          SEG_ACT_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_in,
  input  logic       start_stop,
  input  logic       clr,
  output logic [7:0] cnt_bcd,
  output logic       carry,
  output logic       running,
  output logic [7:0] seg,
  output logic [1:0] dig_sel
);

  localparam int unsigned SCAN_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [3:0]  MAX_TENS  = 4'(CNT_MAX / 10);
  localparam logic [3:0]  MAX_ONES  = 4'(CNT_MAX % 10);
  localparam logic [7:0]  MAX_BCD   = {MAX_TENS, MAX_ONES};
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [7:0]  SEG_OFF   = SEG_ACT_LOW ? 8'hFF : 8'h00;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic              tick_d_q, tick_d_d;
  logic              running_q, running_d;
  logic              carry_q, carry_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic              idx_q, idx_d;
  logic [1:0]        dig_sel_q, dig_sel_d;
  logic [7:0]        seg_q, seg_d;

  logic              tick_rise;
  logic              scan_wrap;
  logic [3:0]        cur_digit;
  logic [7:0]        seg_raw;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'h3F;
      4'd1:    g = 7'h06;
      4'd2:    g = 7'h5B;
      4'd3:    g = 7'h4F;
      4'd4:    g = 7'h66;
      4'd5:    g = 7'h6D;
      4'd6:    g = 7'h7D;
      4'd7:    g = 7'h07;
      4'd8:    g = 7'h7F;
      4'd9:    g = 7'h6F;
      default: g = 7'h00;
    endcase
    return g;
  endfunction

  // RUN/STOP control; clr always dominates start_stop.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ST_STOP;
    end else if (start_stop) begin
      state_d = (state_q == ST_RUN) ? ST_STOP : ST_RUN;
    end
    running_d = (state_d == ST_RUN);
  end

  // Counting is gated by the state before this edge, so a start coinciding
  // with a rise is not counted and a stop coinciding with a rise is.
  always_comb begin
    tick_d_d  = tick_in;
    tick_rise = tick_in & ~tick_d_q;
    cnt_d     = cnt_q;
    carry_d   = 1'b0;
    if (clr) begin
      cnt_d = 8'h00;
    end else if (tick_rise && (state_q == ST_RUN)) begin
      if (cnt_q == MAX_BCD) begin
        cnt_d   = 8'h00;
        carry_d = 1'b1;
      end else if (cnt_q[3:0] == 4'd9) begin
        cnt_d = {cnt_q[7:4] + 4'd1, 4'd0};
      end else begin
        cnt_d = {cnt_q[7:4], cnt_q[3:0] + 4'd1};
      end
    end
  end

  always_comb begin
    scan_wrap = (scan_q == SCAN_LAST);
    scan_d    = scan_wrap ? '0 : scan_q + SCAN_W'(1);
    idx_d     = idx_q ^ scan_wrap;
  end

  // Output stage decodes the slot selected by the current digit index.
  always_comb begin
    cur_digit = idx_q ? cnt_q[7:4] : cnt_q[3:0];
    seg_raw   = {(~idx_q) & running_q, glyph(cur_digit)};
`ifdef LEAD_ZERO_BLANK_EN
    if (idx_q && (cnt_q[7:4] == 4'd0)) begin
      seg_raw = 8'h00;
    end
`endif
    seg_d     = SEG_ACT_LOW ? ~seg_raw : seg_raw;
    dig_sel_d = idx_q ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_STOP;
      tick_d_q  <= 1'b0;
      running_q <= 1'b0;
      carry_q   <= 1'b0;
      cnt_q     <= 8'h00;
      scan_q    <= '0;
      idx_q     <= 1'b0;
      dig_sel_q <= 2'b11;
      seg_q     <= SEG_OFF;
    end else begin
      state_q   <= state_d;
      tick_d_q  <= tick_d_d;
      running_q <= running_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      scan_q    <= scan_d;
      idx_q     <= idx_d;
      dig_sel_q <= dig_sel_d;
      seg_q     <= seg_d;
    end
  end

  assign cnt_bcd = cnt_q;
  assign carry   = carry_q;
  assign running = running_q;
  assign seg     = seg_q;
  assign dig_sel = dig_sel_q;

endmodule
